// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one combinational ALU behind a one-entry response slot.
// Optional build macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins ties (default is round-robin).
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic [2:0]       req0_ctrl_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  input  logic [2:0]       req1_ctrl_i,
  output logic             rsp0_valid_o,
  input  logic             rsp0_ready_i,
  output logic             rsp1_valid_o,
  input  logic             rsp1_ready_i,
  output logic [WIDTH-1:0] rsp_result_o
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HELD  = 1'b1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [0:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             lastGrant_q, lastGrant_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             ownerDrain;
  logic             slotFree;
  logic             tieWinner;
  logic             grantIdx;
  logic             fire;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [2:0]       opCtrl;
  logic [WIDTH-1:0] aluOut;

  // Unsupported opcodes fall through to zero so the slot never captures X.
  function automatic logic [WIDTH-1:0] aluOp(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [2:0]       ctrl);
    logic [WIDTH-1:0] res;
    res = '0;
    case (ctrl)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: res = '0;
    endcase
    return res;
  endfunction

  assign ownerDrain = (state_q == ST_HELD) && (owner_q ? rsp1_ready_i : rsp0_ready_i);
  assign slotFree   = (state_q == ST_EMPTY) || ownerDrain;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign tieWinner = 1'b0;
`else
  assign tieWinner = ~lastGrant_q;
`endif

  always_comb begin
    grantIdx = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      grantIdx = tieWinner;
    end else if (req1_valid_i) begin
      grantIdx = 1'b1;
    end
  end

  assign fire         = slotFree && (req0_valid_i || req1_valid_i);
  assign req0_ready_o = fire && (grantIdx == 1'b0);
  assign req1_ready_o = fire && (grantIdx == 1'b1);

  assign opA    = grantIdx ? req1_a_i    : req0_a_i;
  assign opB    = grantIdx ? req1_b_i    : req0_b_i;
  assign opCtrl = grantIdx ? req1_ctrl_i : req0_ctrl_i;
  assign aluOut = aluOp(opA, opB, opCtrl);

  // A fire always wins over a plain drain, which is what makes drain+refill back-to-back.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lastGrant_d = lastGrant_q;
    result_d    = result_q;
    if (fire) begin
      state_d     = ST_HELD;
      owner_d     = grantIdx;
      lastGrant_d = grantIdx;
      result_d    = aluOut;
    end else if (ownerDrain) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_EMPTY;
      owner_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lastGrant_q <= lastGrant_d;
      result_q    <= result_d;
    end
  end

  assign rsp0_valid_o = (state_q == ST_HELD) && (owner_q == 1'b0);
  assign rsp1_valid_o = (state_q == ST_HELD) && (owner_q == 1'b1);
  assign rsp_result_o = result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; expected values are hand-computed constants.
// Honours ALU_ARB_FIXED_PRIO_EN when predicting tie outcomes.
module tb_alu_arbiter;

  localparam int WIDTH = 32;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic             req0_valid_i, req1_valid_i;
  logic             req0_ready_o, req1_ready_o;
  logic [WIDTH-1:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
  logic [2:0]       req0_ctrl_i, req1_ctrl_i;
  logic             rsp0_valid_o, rsp1_valid_o;
  logic             rsp0_ready_i, rsp1_ready_i;
  logic [WIDTH-1:0] rsp_result_o;

  int vecCount = 0;
  int errCount = 0;
  logic expLast;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_a_i(req0_a_i), .req0_b_i(req0_b_i), .req0_ctrl_i(req0_ctrl_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_a_i(req1_a_i), .req1_b_i(req1_b_i), .req1_ctrl_i(req1_ctrl_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i),
    .rsp_result_o(rsp_result_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance past the next rising edge so registered outputs are settled.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic v0, input logic [2:0] c0,
                               input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                               input logic v1, input logic [2:0] c1,
                               input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1);
    req0_valid_i = v0; req0_ctrl_i = c0; req0_a_i = a0; req0_b_i = b0;
    req1_valid_i = v1; req1_ctrl_i = c1; req1_a_i = a1; req1_b_i = b1;
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    rsp0_ready_i = 1'b0;
    rsp1_ready_i = 1'b0;
    applyStimulus(1'b0, 3'b000, '0, '0, 1'b0, 3'b000, '0, '0);
    tick();
    tick();
    vecCount++;
    if (rsp0_valid_o !== 1'b0 || rsp1_valid_o !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL reset_valid: got rsp0=%b rsp1=%b, want 0 0", rsp0_valid_o, rsp1_valid_o);
    end
    vecCount++;
    if (rsp_result_o !== 32'h0) begin
      errCount++;
      $display("[TB] FAIL reset_result: got %h, want 00000000", rsp_result_o);
    end
    reset_i = 1'b0;
    expLast = 1'b1;
  endtask

  task automatic test_add();
    rsp0_ready_i = 1'b1;
    applyStimulus(1'b1, 3'b010, 32'd5, 32'd7, 1'b0, 3'b000, '0, '0);
    vecCount++;
    if (req0_ready_o !== 1'b1 || req1_ready_o !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL add_ready: got r0=%b r1=%b, want 1 0", req0_ready_o, req1_ready_o);
    end
    tick();
    expLast = 1'b0;
    vecCount++;
    if (rsp0_valid_o !== 1'b1 || rsp1_valid_o !== 1'b0 || rsp_result_o !== 32'd12) begin
      errCount++;
      $display("[TB] FAIL add_rsp: got v0=%b v1=%b res=%h, want 1 0 0000000c",
               rsp0_valid_o, rsp1_valid_o, rsp_result_o);
    end
    applyStimulus(1'b0, 3'b000, '0, '0, 1'b0, 3'b000, '0, '0);
    tick();
    vecCount++;
    if (rsp0_valid_o !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL add_drain: got rsp0_valid=%b, want 0", rsp0_valid_o);
    end
  endtask

  task automatic test_round_robin();
    logic w;
    logic [WIDTH-1:0] expRes;
    rsp0_ready_i = 1'b1;
    rsp1_ready_i = 1'b1;
    // req0: 10+20=30, req1: 50-8=42
    applyStimulus(1'b1, 3'b010, 32'd10, 32'd20, 1'b1, 3'b110, 32'd50, 32'd8);
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      w = 1'b0;
`else
      w = ~expLast;
`endif
      vecCount++;
      if (req0_ready_o !== ~w || req1_ready_o !== w) begin
        errCount++;
        $display("[TB] FAIL rr_grant[%0d]: got r0=%b r1=%b, want %b %b",
                 i, req0_ready_o, req1_ready_o, ~w, w);
      end
      tick();
      #1;
      expLast = w;
      expRes  = w ? 32'd42 : 32'd30;
      vecCount++;
      if (rsp0_valid_o !== ~w || rsp1_valid_o !== w || rsp_result_o !== expRes) begin
        errCount++;
        $display("[TB] FAIL rr_rsp[%0d]: got v0=%b v1=%b res=%h, want %b %b %h",
                 i, rsp0_valid_o, rsp1_valid_o, rsp_result_o, ~w, w, expRes);
      end
    end
    applyStimulus(1'b0, 3'b000, '0, '0, 1'b0, 3'b000, '0, '0);
    tick();
    vecCount++;
    if (rsp0_valid_o !== 1'b0 || rsp1_valid_o !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL rr_drain: got v0=%b v1=%b, want 0 0", rsp0_valid_o, rsp1_valid_o);
    end
  endtask

  task automatic test_backpressure();
    rsp0_ready_i = 1'b1;
    rsp1_ready_i = 1'b0;
    applyStimulus(1'b0, 3'b000, '0, '0, 1'b1, 3'b110, 32'd3, 32'd5);
    vecCount++;
    if (req1_ready_o !== 1'b1 || req0_ready_o !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL bp_accept: got r0=%b r1=%b, want 0 1", req0_ready_o, req1_ready_o);
    end
    tick();
    expLast = 1'b1;
    applyStimulus(1'b1, 3'b000, 32'hF0, 32'hFF, 1'b0, 3'b000, '0, '0);
    for (int i = 0; i < 4; i++) begin
      vecCount++;
      if (rsp1_valid_o !== 1'b1 || rsp0_valid_o !== 1'b0 || rsp_result_o !== 32'hFFFF_FFFE) begin
        errCount++;
        $display("[TB] FAIL bp_hold[%0d]: got v0=%b v1=%b res=%h, want 0 1 fffffffe",
                 i, rsp0_valid_o, rsp1_valid_o, rsp_result_o);
      end
      vecCount++;
      if (req0_ready_o !== 1'b0 || req1_ready_o !== 1'b0) begin
        errCount++;
        $display("[TB] FAIL bp_block[%0d]: got r0=%b r1=%b, want 0 0", i, req0_ready_o, req1_ready_o);
      end
      tick();
    end
    rsp1_ready_i = 1'b1;
    #1;
    vecCount++;
    if (req0_ready_o !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL bp_release: got req0_ready=%b, want 1", req0_ready_o);
    end
    tick();
    expLast = 1'b0;
    vecCount++;
    if (rsp1_valid_o !== 1'b0 || rsp0_valid_o !== 1'b1 || rsp_result_o !== 32'hF0) begin
      errCount++;
      $display("[TB] FAIL bp_refill: got v0=%b v1=%b res=%h, want 1 0 000000f0",
               rsp0_valid_o, rsp1_valid_o, rsp_result_o);
    end
    applyStimulus(1'b0, 3'b000, '0, '0, 1'b0, 3'b000, '0, '0);
    tick();
  endtask

  task automatic test_opcode_sweep();
    logic [2:0]       ctrlTab [9];
    logic [WIDTH-1:0] aTab    [9];
    logic [WIDTH-1:0] bTab    [9];
    logic [WIDTH-1:0] expTab  [9];
    ctrlTab = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b101, 3'b111};
    aTab    = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0001};
    bTab    = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h8000_0000};
    expTab  = '{32'h0, 32'h8000_0001, 32'h8000_0001, 32'h7FFF_FFFF, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h1};
    rsp0_ready_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, ctrlTab[i], aTab[i], bTab[i], 1'b0, 3'b000, '0, '0);
      tick();
      vecCount++;
      if (rsp0_valid_o !== 1'b1 || rsp_result_o !== expTab[i]) begin
        errCount++;
        $display("[TB] FAIL op_%b_%0d: got v0=%b res=%h, want 1 %h",
                 ctrlTab[i], i, rsp0_valid_o, rsp_result_o, expTab[i]);
      end
    end
    expLast = 1'b0;
    applyStimulus(1'b0, 3'b000, '0, '0, 1'b0, 3'b000, '0, '0);
    tick();
  endtask

  task automatic test_reset_mid();
    rsp0_ready_i = 1'b0;
    rsp1_ready_i = 1'b0;
    applyStimulus(1'b0, 3'b000, '0, '0, 1'b1, 3'b010, 32'd1, 32'd1);
    tick();
    applyStimulus(1'b0, 3'b000, '0, '0, 1'b0, 3'b000, '0, '0);
    vecCount++;
    if (rsp1_valid_o !== 1'b1 || rsp_result_o !== 32'd2) begin
      errCount++;
      $display("[TB] FAIL mid_held: got v1=%b res=%h, want 1 00000002", rsp1_valid_o, rsp_result_o);
    end
    reset_i = 1'b1;
    tick();
    vecCount++;
    if (rsp0_valid_o !== 1'b0 || rsp1_valid_o !== 1'b0 || rsp_result_o !== 32'h0) begin
      errCount++;
      $display("[TB] FAIL mid_reset: got v0=%b v1=%b res=%h, want 0 0 00000000",
               rsp0_valid_o, rsp1_valid_o, rsp_result_o);
    end
    reset_i = 1'b0;
    rsp0_ready_i = 1'b1;
    rsp1_ready_i = 1'b1;
    applyStimulus(1'b1, 3'b001, 32'h0F, 32'hF0, 1'b1, 3'b010, 32'd2, 32'd2);
    vecCount++;
    if (req0_ready_o !== 1'b1 || req1_ready_o !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL mid_tie: got r0=%b r1=%b, want 1 0", req0_ready_o, req1_ready_o);
    end
    tick();
    vecCount++;
    if (rsp0_valid_o !== 1'b1 || rsp1_valid_o !== 1'b0 || rsp_result_o !== 32'hFF) begin
      errCount++;
      $display("[TB] FAIL mid_first: got v0=%b v1=%b res=%h, want 1 0 000000ff",
               rsp0_valid_o, rsp1_valid_o, rsp_result_o);
    end
    applyStimulus(1'b0, 3'b000, '0, '0, 1'b0, 3'b000, '0, '0);
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_round_robin();
    test_backpressure();
    test_opcode_sweep();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
